sort_feeder: RTL and testbench

Batch producer for the 32-entry insertion sorter. Accepts per-image `{color, total}` results from the divider over a valid/ready handshake and buffers one batch of 32 with arrival-order indices 0..31. Once the sorter is idle, streams the batch as 32 contiguous `in_valid` beats. Then waits for the sorter's 32-beat output burst to finish before accepting the next batch.

---
 rtl/sort_feeder.sv | 165 ++++++++++++++++
 tb/tb_sort_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_feeder.sv
// Collects one 32-entry batch of {color,total} results and streams it to the insertion sorter.
// Define SORT_FEEDER_PAD_EN to let flush close a partial batch, padding the rest with all-ones beats.
module sort_feeder #(
  parameter int TOTAL_W = 23,
  parameter int COLOR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_valid,
  input  logic [COLOR_W-1:0] div_color,
  input  logic [TOTAL_W-1:0] div_total,
  output logic               div_ready,
  input  logic               flush,
  input  logic               sort_busy_rst,
  input  logic               sort_out_valid,
  output logic               in_valid,
  output logic [COLOR_W-1:0] color,
  output logic [TOTAL_W-1:0] total,
  output logic [4:0]         index,
  output logic               batch_done,
  output logic [7:0]         batch_cnt,
  output logic               err
);

  localparam int ENTRY_W = COLOR_W + TOTAL_W;

  typedef enum logic [1:0] {FILL, WAIT_IDLE, SEND, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [5:0]           wr_cnt_q, wr_cnt_d;
  logic [5:0]           send_cnt_q, send_cnt_d;
  logic                 seen_q, seen_d;
  logic                 in_valid_q, in_valid_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [4:0]           index_q, index_d;
  logic                 batch_done_q, batch_done_d;
  logic [7:0]           batch_cnt_q, batch_cnt_d;
  logic                 err_q, err_d;
  logic [ENTRY_W-1:0]   mem_q [32];

  logic                 accept;
  logic [5:0]           wr_cnt_inc;
  logic [4:0]           beat_idx;
  logic [ENTRY_W-1:0]   beat_entry;

  assign div_ready  = (state_q == FILL);
  assign accept     = div_valid && div_ready;
  assign wr_cnt_inc = wr_cnt_q + {5'd0, accept};

`ifndef SORT_FEEDER_PAD_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_cnt_q[4:0]] <= {div_color, div_total};
  end

  // Beat source: buffer entry, or an all-ones pad past the filled count
  always_comb begin
    beat_idx   = (state_q == SEND) ? send_cnt_q[4:0] : 5'd0;
    beat_entry = mem_q[beat_idx];
`ifdef SORT_FEEDER_PAD_EN
    if ({1'b0, beat_idx} >= wr_cnt_q) beat_entry = '1;
`endif
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    send_cnt_d   = send_cnt_q;
    seen_d       = seen_q;
    in_valid_d   = in_valid_q;
    color_d      = color_q;
    total_d      = total_q;
    index_d      = index_q;
    batch_done_d = 1'b0;
    batch_cnt_d  = batch_cnt_q;
    err_d        = err_q;
    case (state_q)
      FILL: begin
        wr_cnt_d = wr_cnt_inc;
        if (wr_cnt_inc == 6'd32) state_d = WAIT_IDLE;
`ifdef SORT_FEEDER_PAD_EN
        else if (flush && (wr_cnt_inc != 6'd0)) state_d = WAIT_IDLE;
`endif
      end
      WAIT_IDLE: begin
        if (sort_busy_rst && !sort_out_valid) begin
          state_d              = SEND;
          in_valid_d           = 1'b1;
          {color_d, total_d}   = beat_entry;
          index_d              = beat_idx;
          send_cnt_d           = 6'd1;
        end
      end
      SEND: begin
        // send_cnt_q==1 marks the first edge spent in SEND
        if (sort_out_valid) err_d = 1'b1;
        if ((send_cnt_q == 6'd1) && !sort_busy_rst) err_d = 1'b1;
        if (send_cnt_q == 6'd32) begin
          state_d    = DRAIN;
          in_valid_d = 1'b0;
          color_d    = '0;
          total_d    = '0;
          index_d    = '0;
          send_cnt_d = '0;
        end else begin
          {color_d, total_d} = beat_entry;
          index_d            = beat_idx;
          send_cnt_d         = send_cnt_q + 6'd1;
        end
      end
      DRAIN: begin
        if (sort_out_valid) seen_d = 1'b1;
        if (seen_q && !sort_out_valid) begin
          state_d      = FILL;
          batch_done_d = 1'b1;
          batch_cnt_d  = batch_cnt_q + 8'd1;
          wr_cnt_d     = '0;
          seen_d       = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      send_cnt_q   <= '0;
      seen_q       <= 1'b0;
      in_valid_q   <= 1'b0;
      color_q      <= '0;
      total_q      <= '0;
      index_q      <= '0;
      batch_done_q <= 1'b0;
      batch_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      send_cnt_q   <= send_cnt_d;
      seen_q       <= seen_d;
      in_valid_q   <= in_valid_d;
      color_q      <= color_d;
      total_q      <= total_d;
      index_q      <= index_d;
      batch_done_q <= batch_done_d;
      batch_cnt_q  <= batch_cnt_d;
      err_q        <= err_d;
    end
  end

  assign in_valid   = in_valid_q;
  assign color      = color_q;
  assign total      = total_q;
  assign index      = index_q;
  assign batch_done = batch_done_q;
  assign batch_cnt  = batch_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sort_feeder.sv
// Bench for sort_feeder: table of batch scenarios plus hand sequences for flush, errors and reset.
// Build with SORT_FEEDER_PAD_EN defined to exercise padded partial batches.
module tb_sort_feeder;
  localparam int TOTAL_W = 23;
  localparam int COLOR_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               div_valid = 1'b0;
  logic [COLOR_W-1:0] div_color = '0;
  logic [TOTAL_W-1:0] div_total = '0;
  logic               div_ready;
  logic               flush = 1'b0;
  logic               sort_busy_rst = 1'b1;
  logic               sort_out_valid;
  logic               in_valid;
  logic [COLOR_W-1:0] color;
  logic [TOTAL_W-1:0] total;
  logic [4:0]         index;
  logic               batch_done;
  logic [7:0]         batch_cnt;
  logic               err;

  logic sov_model = 1'b0;
  logic sov_inject = 1'b0;
  assign sort_out_valid = sov_model | sov_inject;

  sort_feeder #(.TOTAL_W(TOTAL_W), .COLOR_W(COLOR_W)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_color(div_color),
    .div_total(div_total), .div_ready(div_ready), .flush(flush),
    .sort_busy_rst(sort_busy_rst), .sort_out_valid(sort_out_valid),
    .in_valid(in_valid), .color(color), .total(total), .index(index),
    .batch_done(batch_done), .batch_cnt(batch_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int drop_cyc = 0;
  int acc_cnt = 0;
  int batch_pos = 0;
  int model_gap = 0;
  logic [29:0] sb[$];

  typedef struct {
    int mult;
    int offs;
    int delay;
    int gap;
    int exp_lat;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_n++;

  // Scoreboard: push on accepted results, pop on each beat to the sorter
  always @(negedge clk) begin
    logic [29:0] exp_beat;
    if (!rst) begin
      batch_pos = 0;
    end else begin
      if (in_valid) begin
        if (sb.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
        else begin
          exp_beat = sb.pop_front();
          check("beat", {2'b00, color, total, index}, {2'b00, exp_beat});
        end
      end
      if (batch_done) batch_pos = 0;
      if (div_valid && div_ready) begin
        sb.push_back({div_color, div_total, batch_pos[4:0]});
        batch_pos++;
        acc_cnt++;
      end
    end
  end

  // Sorter model: 32-cycle output burst starting model_gap cycles after in_valid falls
  int prev_iv = 0;
  int gap_left = -1;
  int sov_left = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_iv = 0; gap_left = -1; sov_left = 0; sov_model = 1'b0;
    end else begin
      if (prev_iv != 0 && !in_valid) gap_left = model_gap;
      if (gap_left == 0) begin sov_left = 32; gap_left = -1; end
      else if (gap_left > 0) gap_left--;
      if (sov_left > 0) begin sov_model = 1'b1; sov_left--; end
      else if (sov_model) begin sov_model = 1'b0; drop_cyc = cyc_n; end
      prev_iv = in_valid ? 1 : 0;
    end
  end

  task automatic accept_n(input int first, input int n, input int mult, input int offs);
    for (int k = first; k < first + n; k++) begin
      div_valid = 1'b1;
      div_color = COLOR_W'(k % 4);
      div_total = TOTAL_W'(offs + k * mult);
      wait_edge();
    end
    div_valid = 1'b0;
  endtask

  // Called just after the edge that closed the batch
  task automatic finish_batch(input int hold, input int exp_lat, input int exp_cnt);
    int lat, run, w;
    logic ready_seen;
    check("ready_low_after_fill", div_ready, 0);
    lat = 0;
    do begin
      wait_edge();
      lat++;
      if (lat == hold) sort_busy_rst = 1'b1;
    end while (!in_valid && lat < 200);
    sort_busy_rst = 1'b1;
    check("first_beat_latency", lat, exp_lat);
    check("beat0_index", index, 0);
    run = 1;
    for (int b = 1; b < 32; b++) begin
      wait_edge();
      if (in_valid) run++;
    end
    check("beat_run", run, 32);
    check("last_index", index, 31);
    check("ready_low_in_send", div_ready, 0);
    wait_edge();
    check("valid_drop", in_valid, 0);
    check("idle_beat_zero", {2'b00, color, total, index}, 0);
    w = 0;
    ready_seen = 1'b0;
    while (!batch_done && w < 300) begin
      wait_edge();
      w++;
      if (!batch_done) ready_seen |= div_ready;
    end
    check("done_seen", batch_done, 1);
    check("done_timing", cyc_n, drop_cyc + 1);
    check("ready_after_done", div_ready, 1);
    check("ready_low_drain", ready_seen, 0);
    check("batch_cnt", batch_cnt, exp_cnt);
    check("err_clear", err, 0);
    wait_edge();
    check("done_pulse_width", batch_done, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    wait_edge();
    check("rst_in_valid", in_valid, 0);
    check("rst_index", index, 0);
    check("rst_ready", div_ready, 1);
    check("rst_batch_cnt", batch_cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt, base_acc, target;
    vecs[0] = '{3, 0, 0, 0, 1};
    vecs[1] = '{3, 0, 5, 2, 6};
    vecs[2] = '{262144, 7, 1, 0, 2};
    vecs[3] = '{-1, 32'h7FFFFF, 0, 3, 1};
    exp_cnt = 0;

    repeat (3) wait_edge();
    check("reset_in_valid", in_valid, 0);
    check("reset_color", color, 0);
    check("reset_total", total, 0);
    check("reset_index", index, 0);
    check("reset_batch_done", batch_done, 0);
    check("reset_batch_cnt", batch_cnt, 0);
    check("reset_err", err, 0);
    check("reset_ready", div_ready, 1);
    rst = 1'b1;
    wait_edge();

    for (int i = 0; i < 4; i++) begin
      model_gap = vecs[i].gap;
      if (vecs[i].delay > 0) sort_busy_rst = 1'b0;
      accept_n(0, 32, vecs[i].mult, vecs[i].offs);
      exp_cnt++;
      finish_batch(vecs[i].delay, vecs[i].exp_lat, exp_cnt);
    end

    // Continuous source across two batches
    model_gap = 0;
    base_acc = acc_cnt;
    target = exp_cnt + 2;
    div_valid = 1'b1;
    div_color = '0;
    div_total = TOTAL_W'(1);
    for (int c = 0; c < 600 && batch_cnt != 8'(target); c++) begin
      wait_edge();
      div_color = COLOR_W'((acc_cnt - base_acc) % 4);
      div_total = TOTAL_W'((acc_cnt - base_acc) * 5 + 1);
    end
    div_valid = 1'b0;
    check("cont_batch_cnt", batch_cnt, target);
    check("cont_accepts", acc_cnt - base_acc, 64);
    exp_cnt = target;
    wait_edge();
    check("cont_sb_empty", sb.size(), 0);

    // Flush on an empty buffer never starts a batch
    flush = 1'b1;
    wait_edge();
    flush = 1'b0;
    check("flush_empty_ignored", div_ready, 1);

    accept_n(0, 5, 3, 0);
`ifdef SORT_FEEDER_PAD_EN
    for (int k = batch_pos; k < 32; k++) sb.push_back({2'b11, 23'h7FFFFF, 5'(k)});
    flush = 1'b1;
    wait_edge();
    flush = 1'b0;
    exp_cnt++;
    finish_batch(0, 1, exp_cnt);
`else
    flush = 1'b1;
    wait_edge();
    flush = 1'b0;
    check("flush_ignored", div_ready, 1);
    accept_n(5, 27, 3, 0);
    exp_cnt++;
    finish_batch(0, 1, exp_cnt);
`endif

    // Sorter not cleared at the first SEND edge
    accept_n(0, 32, 2, 1);
    wait_edge();
    check("err1_beat0", in_valid, 1);
    sort_busy_rst = 1'b0;
    wait_edge();
    sort_busy_rst = 1'b1;
    check("err_busy", err, 1);
    wait_edge();
    check("err_sticky", err, 1);
    apply_reset();
    exp_cnt = 0;

    // Sorter output active during SEND
    accept_n(0, 32, 2, 1);
    wait_edge();
    check("err2_beat0", in_valid, 1);
    sov_inject = 1'b1;
    wait_edge();
    sov_inject = 1'b0;
    check("err_outvalid", err, 1);
    apply_reset();

    // Reset in the middle of SEND, then a fresh batch
    accept_n(0, 32, 9, 4);
    wait_edge();
    repeat (10) wait_edge();
    check("beat10_index", index, 10);
    apply_reset();
    accept_n(0, 32, 7, 11);
    finish_batch(0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
